// File: rtl/sdram_arbit_if.sv
// Sequencer-to-arbiter request/command bundle and the muxed SDRAM pin side.
// The arbiter takes the slave view; the sequencers (or a bench) take the master view.
interface sdram_arbit_if;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [12:0] init_addr;

  logic        ref_req;
  logic        ref_end;
  logic [3:0]  ref_cmd;
  logic [12:0] ref_addr;

  logic        wr_req;
  logic        wr_end;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  wr_bank;

  logic        rd_req;
  logic        rd_end;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [1:0]  rd_bank;

  logic        ref_en;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic        sdram_cke;
  logic        wd_err;

  modport slave (
    input  init_end, init_cmd, init_addr,
    input  ref_req, ref_end, ref_cmd, ref_addr,
    input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
    input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    output ref_en, wr_en, rd_en,
    output sdram_cmd, sdram_addr, sdram_bank, sdram_cke, wd_err
  );

  modport master (
    output init_end, init_cmd, init_addr,
    output ref_req, ref_end, ref_cmd, ref_addr,
    output wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
    output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    input  ref_en, wr_en, rd_en,
    input  sdram_cmd, sdram_addr, sdram_bank, sdram_cke, wd_err
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: holds the bus for init, then grants refresh first and
// alternates write/read, with a watchdog that reclaims a grant that never ends.
module sdram_arbit #(
  parameter int WD_LIMIT = 1023
) (
  input  logic         sclk,
  input  logic         reset,
  sdram_arbit_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  localparam logic [9:0] WD_LAST = 10'(WD_LIMIT - 1);
  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t      state;
  state_t      state_nxt;
  logic        last_rd;
  logic        last_rd_nxt;
  logic [9:0]  wd_cnt;
  logic [9:0]  wd_cnt_nxt;
  logic        wd_err_r;
  logic        wd_err_nxt;
  logic        seq_end;

  logic [3:0]  cmd_mux;
  logic [12:0] addr_mux;
  logic [1:0]  bank_mux;

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state    <= S_INIT;
      last_rd  <= 1'b1;
      wd_cnt   <= '0;
      wd_err_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_rd  <= last_rd_nxt;
      wd_cnt   <= wd_cnt_nxt;
      wd_err_r <= wd_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_rd_nxt = last_rd;
    wd_cnt_nxt  = '0;
    wd_err_nxt  = 1'b0;
    seq_end     = 1'b0;
    case (state)
      S_INIT: begin
        if (bus.init_end) state_nxt = S_ARBIT;
      end
      S_ARBIT: begin
        // last_rd breaks the tie only when write and read are both waiting
        if (bus.ref_req) begin
          state_nxt = S_AREF;
        end else if (bus.wr_req && bus.rd_req) begin
          if (last_rd) begin
            state_nxt   = S_WRITE;
            last_rd_nxt = 1'b0;
          end else begin
            state_nxt   = S_READ;
            last_rd_nxt = 1'b1;
          end
        end else if (bus.wr_req) begin
          state_nxt   = S_WRITE;
          last_rd_nxt = 1'b0;
        end else if (bus.rd_req) begin
          state_nxt   = S_READ;
          last_rd_nxt = 1'b1;
        end
      end
      S_AREF, S_WRITE, S_READ: begin
        seq_end = (state == S_AREF  && bus.ref_end) ||
                  (state == S_WRITE && bus.wr_end)  ||
                  (state == S_READ  && bus.rd_end);
        if (seq_end) begin
          state_nxt = S_ARBIT;
        end else if (wd_cnt == WD_LAST) begin
          state_nxt  = S_ARBIT;
          wd_err_nxt = 1'b1;
        end else begin
          wd_cnt_nxt = wd_cnt + 10'd1;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Pin mux follows the registered state so a grant owns the pins in its first cycle
  always_comb begin
    cmd_mux  = CMD_NOP;
    addr_mux = '0;
    bank_mux = 2'b00;
    case (state)
      S_INIT: begin
        cmd_mux  = bus.init_cmd;
        addr_mux = bus.init_addr;
      end
      S_AREF: begin
        cmd_mux  = bus.ref_cmd;
        addr_mux = bus.ref_addr;
      end
      S_WRITE: begin
        cmd_mux  = bus.wr_cmd;
        addr_mux = bus.wr_addr;
        bank_mux = bus.wr_bank;
      end
      S_READ: begin
        cmd_mux  = bus.rd_cmd;
        addr_mux = bus.rd_addr;
        bank_mux = bus.rd_bank;
      end
      default: begin
        cmd_mux  = CMD_NOP;
        addr_mux = '0;
        bank_mux = 2'b00;
      end
    endcase
  end

  assign bus.ref_en     = (state == S_AREF);
  assign bus.wr_en      = (state == S_WRITE);
  assign bus.rd_en      = (state == S_READ);
  assign bus.sdram_cmd  = cmd_mux;
  assign bus.sdram_addr = addr_mux;
  assign bus.sdram_bank = bank_mux;
  assign bus.sdram_cke  = 1'b1;
  assign bus.wd_err     = wd_err_r;

endmodule
